imu_event_detector: RTL

IMU_EVENT_DETECTOR -- requirements
Module: imu_event_detector

---
 rtl/imu_event_detector.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/imu_event_detector.sv
// Per-channel threshold event detector with hold-off and release hysteresis for IMU samples.
// Optional macro IMU_EVT_COUNT_EN adds per-channel saturating event counters.
module imu_event_detector #(
  parameter int WIDTH       = 16,
  parameter int NUM_CH      = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int HYST        = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid,
  input  logic [NUM_CH*WIDTH-1:0] sample_in,
  input  logic [WIDTH-1:0]        threshold,
  output logic [NUM_CH*WIDTH-1:0] sample_out,
  output logic                    out_valid,
  output logic [NUM_CH-1:0]       event_flag,
  output logic [NUM_CH-1:0]       event_rise,
  output logic                    any_event
`ifdef IMU_EVT_COUNT_EN
  ,
  input  logic                    evt_clear,
  output logic [NUM_CH*8-1:0]     evt_count
`endif
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
  localparam logic signed [WIDTH:0] HYST_W = (WIDTH + 1)'(HYST);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE} state_t;

  state_t                state_q [NUM_CH];
  state_t                state_d [NUM_CH];
  logic [CW-1:0]         cnt_q   [NUM_CH];
  logic [CW-1:0]         cnt_d   [NUM_CH];
  logic [NUM_CH-1:0]     above;
  logic [NUM_CH-1:0]     below;
  logic [NUM_CH-1:0]     flag_d;
  logic [NUM_CH-1:0]     rise_d;
  logic signed [WIDTH:0] release_lvl;

  // Release level is one bit wider so threshold - HYST never wraps near the negative limit.
  always_comb begin
    release_lvl = $signed({threshold[WIDTH-1], threshold}) - HYST_W;
  end

  always_comb begin
    above  = '0;
    below  = '0;
    flag_d = '0;
    rise_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      above[k] = $signed(sample_in[k*WIDTH +: WIDTH]) > $signed(threshold);
      below[k] = $signed({sample_in[k*WIDTH+WIDTH-1], sample_in[k*WIDTH +: WIDTH]}) < release_lvl;
      if (sample_valid) begin
        case (state_q[k])
          IDLE: begin
            if (above[k]) begin
              if (HOLD_CYCLES == 1) begin
                state_d[k] = ACTIVE;
                cnt_d[k]   = HOLD_C;
              end else begin
                state_d[k] = ARM;
                cnt_d[k]   = CW'(1);
              end
            end
          end
          ARM: begin
            if (above[k]) begin
              cnt_d[k] = cnt_q[k] + CW'(1);
              if (cnt_q[k] + CW'(1) == HOLD_C) begin
                state_d[k] = ACTIVE;
              end
            end else begin
              state_d[k] = IDLE;
              cnt_d[k]   = '0;
            end
          end
          ACTIVE: begin
            // Samples inside the hysteresis band keep the event asserted.
            if (below[k]) begin
              state_d[k] = IDLE;
              cnt_d[k]   = '0;
            end
          end
          default: begin
            state_d[k] = IDLE;
            cnt_d[k]   = '0;
          end
        endcase
      end
      flag_d[k] = (state_d[k] == ACTIVE);
      rise_d[k] = flag_d[k] && (state_q[k] != ACTIVE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
      sample_out <= '0;
      out_valid  <= 1'b0;
      event_flag <= '0;
      event_rise <= '0;
      any_event  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      sample_out <= sample_in;
      out_valid  <= sample_valid;
      event_flag <= flag_d;
      event_rise <= rise_d;
      any_event  <= |flag_d;
    end
  end

`ifdef IMU_EVT_COUNT_EN
  logic [7:0] evt_cnt_q [NUM_CH];

  // Counts track rise_d so a count step lines up with the visible event_rise pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        evt_cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (evt_clear) begin
          evt_cnt_q[k] <= '0;
        end else if (rise_d[k] && (evt_cnt_q[k] != 8'hFF)) begin
          evt_cnt_q[k] <= evt_cnt_q[k] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    evt_count = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      evt_count[k*8 +: 8] = evt_cnt_q[k];
    end
  end
`endif

endmodule
